// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction fetch with a request/grant/response
// memory interface, an in-order {pc, instr} queue feeding decode, and a
// redirect path that flushes queued words and discards in-flight responses.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pcplus4,
  input  logic        id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  // count, inflight and drop all span 0..DEPTH inclusive
  localparam int CNT_W = PTR_W + 1;
  // queued + in-flight can momentarily be summed up to 2*DEPTH
  localparam int SUM_W = CNT_W + 1;

  // Force a fetch target onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Next sequential fetch address.
  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  // Control state
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] drop;
  logic [PTR_W-1:0] pf_rd;
  logic [PTR_W-1:0] pf_wr;

  // Data storage (never reset; validity is tracked by the control state)
  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];
  logic [31:0] pf_pc   [DEPTH];

  // Per-cycle events
  logic [SUM_W-1:0] credit_used;
  logic             grant;
  logic             rsp;
  logic             rsp_keep;
  logic             deq;

  // Issue, response and dequeue qualification from registered state
  always_comb begin
    credit_used = SUM_W'(inflight) + SUM_W'(count);
    imem_req    = !reset && !redirect && (credit_used < SUM_W'(DEPTH));
    imem_addr   = fetch_pc;
    grant       = imem_req && imem_gnt;
    // a response with nothing outstanding is a protocol violation and ignored
    rsp         = imem_rvalid && (inflight != '0);
    // stale responses (drop pending) and anything returning during a
    // redirect never reach the queue
    rsp_keep    = rsp && (drop == '0) && !redirect;
    id_valid    = !reset && !redirect && (count != '0);
    deq         = id_valid && id_ready;
    id_instr    = q_instr[rd_ptr];
    id_pc       = q_pc[rd_ptr];
    id_pcplus4  = next_word(q_pc[rd_ptr]);
  end

  // Control registers: fetch pointer, queue/pc-FIFO pointers and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      pf_rd    <= '0;
      pf_wr    <= '0;
    end else begin
      // the pc FIFO always holds exactly one tag per outstanding request,
      // including requests that will be discarded after a redirect
      if (grant) begin
        pf_wr <= pf_wr + PTR_W'(1);
      end
      if (rsp) begin
        pf_rd <= pf_rd + PTR_W'(1);
      end

      if (redirect) begin
        fetch_pc <= align_word(redirect_pc);
        rd_ptr   <= wr_ptr;
        count    <= '0;
        inflight <= inflight - CNT_W'(rsp);
        drop     <= inflight - CNT_W'(rsp);
      end else begin
        if (grant) begin
          fetch_pc <= next_word(fetch_pc);
        end
        inflight <= inflight + CNT_W'(grant) - CNT_W'(rsp);
        if (rsp && (drop != '0)) begin
          drop <= drop - CNT_W'(1);
        end
        if (rsp_keep) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(rsp_keep) - CNT_W'(deq);
      end
    end
  end

  // Data registers: tag each grant with its pc, store kept responses
  always_ff @(posedge clk) begin
    if (grant) begin
      pf_pc[pf_wr] <= fetch_pc;
    end
    if (rsp_keep) begin
      q_pc[wr_ptr]    <= pf_pc[pf_rd];
      q_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model with
// configurable latency, program-order scoreboard for decode deliveries.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;
  logic        id_ready;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pcplus4 (id_pcplus4),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  int stall_pct = 0;
  int ngrant = 0;

  // memory model: outstanding requests in order, each with earliest reply cycle
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  // reference model: next expected decode pc and next expected fetch address
  logic [31:0] exp_pc;
  logic [31:0] fetch_exp;
  logic [31:0] dq_pcs [$];
  logic [31:0] grant_addrs [$];

  task automatic drive_mem();
    if (mq_addr.size() > 0 && mq_due[0] <= cyc && $urandom_range(99) >= stall_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq_addr[0] ^ KEY;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  task automatic settle();
    drive_mem();
    #1;
  endtask

  // account for what happens at the coming edge, then advance one cycle
  task automatic commit();
    if (reset) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
      end
      checks++;
      if (id_valid !== 1'b0) begin
        errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid);
      end
      mq_addr.delete();
      mq_due.delete();
      exp_pc    = RESET_PC;
      fetch_exp = RESET_PC;
    end else begin
      if (imem_req === 1'b1) begin
        checks++;
        if (imem_addr !== fetch_exp) begin
          errors++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, fetch_exp);
        end
      end
      if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
        grant_addrs.push_back(imem_addr);
        ngrant++;
        fetch_exp = fetch_exp + 32'd4;
      end
      if (id_valid === 1'b1 && id_ready === 1'b1) begin
        checks++;
        if (id_pc !== exp_pc) begin
          errors++; $display("FAIL deliver_pc: got %h expected %h", id_pc, exp_pc);
        end
        checks++;
        if (id_instr !== (exp_pc ^ KEY)) begin
          errors++; $display("FAIL deliver_instr: got %h expected %h", id_instr, exp_pc ^ KEY);
        end
        checks++;
        if (id_pcplus4 !== exp_pc + 32'd4) begin
          errors++; $display("FAIL deliver_pcplus4: got %h expected %h", id_pcplus4, exp_pc + 32'd4);
        end
        dq_pcs.push_back(id_pc);
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect) begin
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
          errors++; $display("FAIL redirect_gating: got valid=%b req=%b expected 0 0", id_valid, imem_req);
        end
        exp_pc    = redirect_pc & 32'hFFFF_FFFC;
        fetch_exp = redirect_pc & 32'hFFFF_FFFC;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    settle();
    commit();
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; id_ready = 1'b0; imem_gnt = 1'b0; stall_pct = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0; imem_gnt = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    checks++;
    if (imem_addr !== RESET_PC) begin
      errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
    end
    checks++;
    if (imem_req !== 1'b1 || id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got req=%b valid=%b expected 1 0", imem_req, id_valid);
    end
    commit();
  endtask

  task automatic test_stream();
    do_reset();
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      settle();
      checks++;
      if (id_valid !== (k >= 2)) begin
        errors++; $display("FAIL stream_valid k=%0d: got %b expected %b", k, id_valid, k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (id_pc !== 32'(4 * (k - 2))) begin
          errors++; $display("FAIL stream_pc k=%0d: got %h expected %h", k, id_pc, 32'(4 * (k - 2)));
        end
      end
      commit();
    end
  endtask

  task automatic test_stall();
    int g0;
    do_reset();
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
    g0 = ngrant;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (ngrant - g0 != DEPTH) begin
      errors++; $display("FAIL stall_grants: got %0d expected %0d", ngrant - g0, DEPTH);
    end
    settle();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL stall_req: got %b expected 0", imem_req);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      errors++; $display("FAIL stall_head: got valid=%b pc=%h expected 1 00000000", id_valid, id_pc);
    end
    commit();
    id_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      settle();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== 32'(4 * k)) begin
        errors++; $display("FAIL stall_drain k=%0d: got valid=%b pc=%h expected 1 %h", k, id_valid, id_pc, 32'(4 * k));
      end
      commit();
    end
    for (int k = 0; k < 8; k++) tick();
  endtask

  task automatic test_redirect_inflight();
    int guard;
    int d0;
    do_reset();
    lat = 3; imem_gnt = 1'b1; id_ready = 1'b1;
    guard = 0;
    while (mq_addr.size() < 3 && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 10) begin
      errors++; $display("FAIL redir_setup_timeout: got %0d cycles expected < 10", guard);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    settle();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL redir_valid: got %b expected 0", id_valid);
    end
    commit();
    redirect = 1'b0;
    d0 = dq_pcs.size();
    settle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_target_req: got req=%b addr=%h expected 1 00000100", imem_req, imem_addr);
    end
    commit();
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (dq_pcs.size() <= d0) begin
      errors++; $display("FAIL redir_no_delivery: got %0d expected > %0d", dq_pcs.size(), d0);
    end else if (dq_pcs[d0] !== 32'h0000_0100) begin
      errors++; $display("FAIL redir_first_pc: got %h expected 00000100", dq_pcs[d0]);
    end
  endtask

  task automatic test_redirect_rsp();
    int d0;
    do_reset();
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    id_ready = 1'b1;
    settle();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      errors++; $display("FAIL rsp_setup_head: got valid=%b pc=%h expected 1 00000000", id_valid, id_pc);
    end
    redirect = 1'b1; redirect_pc = 32'h0000_2000;
    #1;
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL rsp_redirect_gate: got valid=%b req=%b expected 0 0", id_valid, imem_req);
    end
    commit();
    redirect = 1'b0;
    d0 = dq_pcs.size();
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (dq_pcs.size() <= d0) begin
      errors++; $display("FAIL rsp_no_delivery: got %0d expected > %0d", dq_pcs.size(), d0);
    end else if (dq_pcs[d0] !== 32'h0000_2000) begin
      errors++; $display("FAIL rsp_first_pc: got %h expected 00002000", dq_pcs[d0]);
    end
  endtask

  task automatic test_wrap();
    int g0;
    bit seen;
    lat = 1; imem_gnt = 1'b1; id_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    g0 = grant_addrs.size();
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (id_valid === 1'b1 && id_pc === 32'hFFFF_FFFC) begin
        seen = 1'b1;
        checks++;
        if (id_pcplus4 !== 32'h0) begin
          errors++; $display("FAIL wrap_pcplus4: got %h expected 00000000", id_pcplus4);
        end
      end
      commit();
    end
    checks++;
    if (grant_addrs.size() < g0 + 3) begin
      errors++; $display("FAIL wrap_grants: got %0d expected >= 3", grant_addrs.size() - g0);
    end else if (grant_addrs[g0] !== 32'hFFFF_FFF8 || grant_addrs[g0+1] !== 32'hFFFF_FFFC ||
                 grant_addrs[g0+2] !== 32'h0) begin
      errors++; $display("FAIL wrap_addrs: got %h %h %h expected fffffff8 fffffffc 00000000",
                         grant_addrs[g0], grant_addrs[g0+1], grant_addrs[g0+2]);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL wrap_seen: got 0 expected 1");
    end
  endtask

  task automatic test_reset_mid();
    int g0;
    int d0;
    do_reset();
    lat = 3; imem_gnt = 1'b1; id_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    reset = 1'b1;
    settle();
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got req=%b valid=%b expected 0 0", imem_req, id_valid);
    end
    commit();
    reset = 1'b0;
    g0 = ngrant;
    settle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++; $display("FAIL midreset_restart: got req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    commit();
    for (int k = 0; k < 14; k++) tick();
    checks++;
    if (ngrant - g0 != DEPTH) begin
      errors++; $display("FAIL midreset_credit: got %0d grants expected %0d", ngrant - g0, DEPTH);
    end
    id_ready = 1'b1;
    d0 = dq_pcs.size();
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (dq_pcs.size() < d0 + 4) begin
      errors++; $display("FAIL midreset_drain: got %0d expected >= 4", dq_pcs.size() - d0);
    end else if (dq_pcs[d0] !== RESET_PC || dq_pcs[d0+3] !== RESET_PC + 32'd12) begin
      errors++; $display("FAIL midreset_order: got %h..%h expected %h..%h", dq_pcs[d0], dq_pcs[d0+3],
                         RESET_PC, RESET_PC + 32'd12);
    end
  endtask

  task automatic test_random();
    int d0;
    do_reset();
    d0 = dq_pcs.size();
    stall_pct = 20;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) lat = 1 + int'($urandom_range(2));
      imem_gnt    = ($urandom_range(99) < 75);
      id_ready    = ($urandom_range(99) < 70);
      redirect    = ($urandom_range(99) < 3);
      redirect_pc = $urandom;
      reset       = (i % 997 == 996);
      tick();
    end
    reset = 1'b0; redirect = 1'b0; stall_pct = 0;
    checks++;
    if (dq_pcs.size() - d0 < 300) begin
      errors++; $display("FAIL random_throughput: got %0d deliveries expected >= 300", dq_pcs.size() - d0);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    exp_pc = RESET_PC; fetch_exp = RESET_PC;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_rsp();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
